// File: rtl/goldschmidt_ctrl_if.sv
// Control bundle between the Goldschmidt sequencer and its user: the request side
// drives start/abort/iters, and the sequencer returns the datapath selects and status.
interface goldschmidt_ctrl_if #(
   parameter int ITER_W = 3
);
   logic              start;
   logic              abort;
   logic [ITER_W-1:0] iters;
   logic              kSelect;
   logic [1:0]        ndSelect;
   logic              nEnable;
   logic              dEnable;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, iters,
      input  kSelect, ndSelect, nEnable, dEnable, busy, done
   );

   modport slave (
      input  start, abort, iters,
      output kSelect, ndSelect, nEnable, dEnable, busy, done
   );
endinterface

// File: rtl/goldschmidt_ctrl.sv
// Moore sequencer for a Goldschmidt divider: one initial N/D scaling by IA, then
// `iters` refinement steps, each loading N before D because K is derived from D.
module goldschmidt_ctrl #(
   parameter int ITER_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   goldschmidt_ctrl_if.slave ctrl
);
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      N0   = 3'd1,
      D0   = 3'd2,
      NI   = 3'd3,
      DI   = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [ITER_W-1:0] CNT_ONE = ITER_W'(1);

   state_t            state_reg;
   state_t            state_next;
   logic [ITER_W-1:0] cnt_reg;
   logic [ITER_W-1:0] cnt_next;

   logic       k_sel;
   logic [1:0] nd_sel;
   logic       n_en;
   logic       d_en;
   logic       busy_int;
   logic       done_int;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (ctrl.start) begin
               state_next = N0;
               cnt_next   = ctrl.iters;
            end
         end
         N0:   state_next = D0;
         D0:   state_next = (cnt_reg == '0) ? DONE : NI;
         NI:   state_next = DI;
         DI: begin
            // cnt is the number of refinement steps still owed, including this one
            cnt_next   = cnt_reg - CNT_ONE;
            state_next = (cnt_reg == CNT_ONE) ? DONE : NI;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      if (ctrl.abort && busy_int) begin
         state_next = IDLE;
         cnt_next   = '0;
      end
   end

   always_comb begin
      k_sel    = 1'b0;
      nd_sel   = 2'b00;
      n_en     = 1'b0;
      d_en     = 1'b0;
      busy_int = 1'b0;
      done_int = 1'b0;
      case (state_reg)
         N0: begin
            nd_sel   = 2'b01;
            n_en     = 1'b1;
            busy_int = 1'b1;
         end
         D0: begin
            nd_sel   = 2'b00;
            d_en     = 1'b1;
            busy_int = 1'b1;
         end
         NI: begin
            k_sel    = 1'b1;
            nd_sel   = 2'b11;
            n_en     = 1'b1;
            busy_int = 1'b1;
         end
         DI: begin
            k_sel    = 1'b1;
            nd_sel   = 2'b10;
            d_en     = 1'b1;
            busy_int = 1'b1;
         end
         DONE:    done_int = 1'b1;
         default: ;
      endcase
   end

   assign ctrl.kSelect  = k_sel;
   assign ctrl.ndSelect = nd_sel;
   assign ctrl.nEnable  = n_en;
   assign ctrl.dEnable  = d_en;
   assign ctrl.busy     = busy_int;
   assign ctrl.done     = done_int;
endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Scoreboard bench for goldschmidt_ctrl: stimulus pushes expected transactions,
// a negedge monitor checks every cycle and a fixed-point datapath checks the quotient.
module tb_goldschmidt_ctrl;
   localparam int ITER_W = 3;
   localparam int FRAC   = 14;
   localparam longint ONE = longint'(1) << FRAC;

   typedef struct {
      int iters;
      int cut;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   goldschmidt_ctrl_if #(.ITER_W(ITER_W)) bus ();

   goldschmidt_ctrl #(.ITER_W(ITER_W)) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus)
   );

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   bit   mon_en     = 1'b0;

   function automatic longint to_fix(real r);
      return longint'($rtoi(r * real'(ONE) + 0.5));
   endfunction

   // Divider datapath driven by the controller outputs
   longint n_in = to_fix(0.5);
   longint d_in = to_fix(0.75);
   longint ia   = to_fix(1.3333);
   longint n_dp = 0;
   longint d_dp = 0;
   longint k_dp;
   longint m_dp;
   longint p_dp;

   always_comb begin
      k_dp = bus.kSelect ? (2 * ONE - d_dp) : ia;
      case (bus.ndSelect)
         2'b00:   m_dp = d_in;
         2'b01:   m_dp = n_in;
         2'b10:   m_dp = d_dp;
         default: m_dp = n_dp;
      endcase
      p_dp = (m_dp * k_dp + ONE / 2) >>> FRAC;
   end

   always_ff @(posedge clk) begin
      if (bus.nEnable) n_dp <= p_dp;
      if (bus.dEnable) d_dp <= p_dp;
   end

   task automatic check(string name, longint act, longint req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic check_tol(string name, longint act, longint req, longint tol);
      compared++;
      if (act > req + tol || act < req - tol) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, req, tol);
      end
   endtask

   // Expected {kSelect, ndSelect, nEnable, dEnable, busy, done} at cycle c after start
   function automatic logic [6:0] phase_outputs(int c, int it);
      if (c == 1)          return {1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
      if (c == 2)          return {1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
      if (c <= 2 + 2 * it) return (c % 2 == 1) ? {1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0}
                                               : {1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
      if (c == 3 + 2 * it) return {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
      return 7'd0;
   endfunction

   // Monitor
   initial begin
      bit         in_txn;
      int         cyc;
      int         en_cnt;
      exp_t       cur;
      logic [6:0] obs;
      logic [6:0] exp_o;
      bit         cut_end;
      bit         end_now;
      in_txn = 1'b0;
      cyc    = 0;
      en_cnt = 0;
      cur    = '{iters: 0, cut: 0};
      forever begin
         @(negedge clk);
         if (mon_en) begin
            obs = {bus.kSelect, bus.ndSelect, bus.nEnable, bus.dEnable, bus.busy, bus.done};
            check("enables_exclusive", longint'(bus.nEnable & bus.dEnable), 0);
            if (!in_txn) begin
               if (bus.busy) begin
                  if (exp_q.size() == 0) begin
                     compared++;
                     mismatched++;
                     $display("FAIL unexpected_start: busy=1, required busy=0 (no request pending)");
                  end else begin
                     cur    = exp_q.pop_front();
                     in_txn = 1'b1;
                     cyc    = 0;
                     en_cnt = 0;
                  end
               end else begin
                  check("idle_outputs", longint'(obs), 0);
               end
            end
            if (in_txn) begin
               cyc++;
               en_cnt += int'(bus.nEnable) + int'(bus.dEnable);
               cut_end = (cur.cut != 0) && (cyc == cur.cut + 1);
               exp_o   = cut_end ? 7'd0 : phase_outputs(cyc, cur.iters);
               check($sformatf("outputs iters=%0d cut=%0d cycle=%0d", cur.iters, cur.cut, cyc),
                     longint'(obs), longint'(exp_o));
               end_now = cut_end || (cur.cut == 0 && cyc == 3 + 2 * cur.iters) || !bus.busy;
               if (end_now) begin
                  check($sformatf("enable_total iters=%0d cut=%0d", cur.iters, cur.cut),
                        en_cnt, (cur.cut != 0) ? cur.cut : 2 + 2 * cur.iters);
                  if (bus.done) begin
                     check_tol("d_register", d_dp, ONE, 1);
                     check_tol("n_register", n_dp, to_fix(0.6667), 1);
                  end
                  $display("txn iters=%0d cut=%0d end_cycle=%0d enables=%0d done=%0b d=%0d n=%0d",
                           cur.iters, cur.cut, cyc, en_cnt, bus.done, d_dp, n_dp);
                  in_txn = 1'b0;
               end
            end
         end
      end
   end

   task automatic do_txn(int it, int cut, bit use_reset, bit start_in_done, bit abort_with_start);
      int guard;
      exp_q.push_back('{iters: it, cut: (cut >= 1 && cut <= 2 + 2 * it) ? cut : 0});
      bus.iters = it[ITER_W-1:0];
      bus.start = 1'b1;
      bus.abort = abort_with_start;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (cut > 0) begin
         repeat (cut - 1) begin @(posedge clk); #1; end
         if (use_reset) begin
            reset     = 1'b0;
            bus.start = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            reset     = 1'b1;
            bus.start = 1'b0;
         end else begin
            bus.abort = 1'b1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
         end
      end
      guard = 0;
      while (bus.busy && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 40) begin
         compared++;
         mismatched++;
         $display("FAIL busy_timeout: busy=1 after %0d cycles, required busy=0", guard);
      end
      if (bus.done && start_in_done) begin
         bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int it;
      int cut;
      bus.start = 1'b1;
      bus.abort = 1'b0;
      bus.iters = '0;
      reset     = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      reset     = 1'b1;
      @(posedge clk); #1;

      do_txn(3, 0, 1'b0, 1'b1, 1'b0);
      do_txn(0, 0, 1'b0, 1'b0, 1'b0);
      do_txn(7, 0, 1'b0, 1'b0, 1'b0);
      do_txn(3, 5, 1'b0, 1'b0, 1'b0);
      do_txn(3, 0, 1'b0, 1'b0, 1'b0);
      do_txn(3, 4, 1'b1, 1'b0, 1'b0);
      do_txn(2, 0, 1'b0, 1'b0, 1'b1);
      do_txn(2, 7, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         it  = int'($urandom_range(0, 7));
         cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3 + 2 * it)) : 0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         do_txn(it, cut, 1'b0, ($urandom_range(0, 1) == 1), 1'b0);
      end

      repeat (3) begin @(posedge clk); #1; end
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at 500000, required completion");
      $fatal(1, "timeout");
   end
endmodule
